// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional feature macro used by this slice: MISALIGN_TRAP_EN
// (misaligned redirect targets trap into HALT instead of being aligned).
package if_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Byte distance between consecutive instruction words
    localparam logic [2:0]  PC_STEP  = 3'd4;

    // Instruction presented to decode while nothing has been fetched yet
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // True when a byte address sits on a word boundary
    function automatic logic is_word_aligned(input logic [1:0] low_bits);
        is_word_aligned = (low_bits == 2'b00);
    endfunction

endpackage : if_pkg

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection for the fetch controller: hold, step by
// one word, or jump to a redirect target. Holds no state of its own.
// With MISALIGN_TRAP_EN a misaligned target is flagged and the PC is kept;
// without it the target is forced onto a word boundary.
module fetch_pc_gen
    import if_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] aligned_tgt_s;
    logic [ADDR_W-1:0] step_pc_s;

    assign aligned_tgt_s = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign step_pc_s     = pc + ADDR_W'(PC_STEP);

`ifdef MISALIGN_TRAP_EN
    // Flag a redirect whose target does not land on a word boundary
    always_comb begin
        misalign = 1'b0;
        if (redirect_en && !is_word_aligned(redirect_pc[1:0])) begin
            misalign = 1'b1;
        end else begin
            misalign = 1'b0;
        end
    end
`else
    // Low target bits are simply dropped when trapping is not built in
    logic unused_low_bits_s;
    assign unused_low_bits_s = ^redirect_pc[1:0];

    // Misalignment is never reported in this build
    always_comb begin
        misalign = 1'b0;
    end
`endif

    // Redirect beats a sequential step; a trapped redirect keeps the PC
    always_comb begin
        next_pc = pc;
        if (redirect_en) begin
            if (misalign) begin
                next_pc = pc;
            end else begin
                next_pc = aligned_tgt_s;
            end
        end else if (fetch_en) begin
            next_pc = step_pc_s;
        end else begin
            next_pc = pc;
        end
    end

endmodule : fetch_pc_gen

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the instruction ROM and
// registers fetched words toward decode with a valid/ready handshake.
// Supports branch redirects, halt/resume and a count of accepted words.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned redirects).
module instr_fetch_ctrl
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = 7'd4,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [31:0]       rom_data,
    output logic [31:0]       inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    output logic              halted,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  fetch_cnt
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] next_pc_s;
    logic [31:0]       inst_out_r;
    logic [ADDR_W-1:0] inst_pc_r;
    logic              inst_valid_r;
    logic              halted_r;
    logic              misalign_err_r;
    logic [CNT_W-1:0]  fetch_cnt_r;
    logic              accept_s;
    logic              fetch_s;
    logic              redirect_s;
    logic              misalign_s;

    // Handshake, ROM enable and redirect qualification (redirects ignored in BOOT)
    always_comb begin
        accept_s   = 1'b0;
        fetch_s    = 1'b0;
        redirect_s = 1'b0;
        if (inst_valid_r && inst_ready) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == RUN) && (!inst_valid_r || inst_ready) && !redirect_valid) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end
        if (redirect_valid && (state_r != BOOT)) begin
            redirect_s = 1'b1;
        end else begin
            redirect_s = 1'b0;
        end
    end

    fetch_pc_gen #(
        .ADDR_W (ADDR_W)
    ) u_pc_gen (
        .pc          (pc_r),
        .fetch_en    (fetch_s),
        .redirect_en (redirect_s),
        .redirect_pc (redirect_pc),
        .next_pc     (next_pc_s),
        .misalign    (misalign_s)
    );

    // Next sequencer state; a trapped redirect always parks the fetcher in HALT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT: state_nxt_s = RUN;
            RUN: begin
                if (halt_req) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HALT;
                end
            end
            default: state_nxt_s = BOOT;
        endcase
        if (misalign_s) begin
            state_nxt_s = HALT;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Sequencer state, PC, decode-side output register and fetch counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= BOOT;
            halted_r       <= 1'b0;
            pc_r           <= RESET_PC;
            inst_out_r     <= NOP_INST;
            inst_pc_r      <= {ADDR_W{1'b0}};
            inst_valid_r   <= 1'b0;
            misalign_err_r <= 1'b0;
            fetch_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            halted_r       <= (state_nxt_s == HALT);
            pc_r           <= next_pc_s;
            misalign_err_r <= misalign_s;
            // The word taken in a redirect cycle is still counted
            if (accept_s) begin
                fetch_cnt_r <= fetch_cnt_r + CNT_W'(1'b1);
            end
            if (redirect_s) begin
                inst_valid_r <= 1'b0;
            end else if (fetch_s) begin
                inst_out_r   <= rom_data;
                inst_pc_r    <= pc_r;
                inst_valid_r <= 1'b1;
            end else if (accept_s) begin
                inst_valid_r <= 1'b0;
            end
        end
    end

    assign rom_addr     = pc_r;
    assign rom_en       = fetch_s;
    assign inst_out     = inst_out_r;
    assign inst_pc      = inst_pc_r;
    assign inst_valid   = inst_valid_r;
    assign halted       = halted_r;
    assign misalign_err = misalign_err_r;
    assign fetch_cnt    = fetch_cnt_r;

endmodule : instr_fetch_ctrl

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  rom_addr;
    logic        rom_en;
    logic [31:0] rom_data;
    logic [31:0] inst_out;
    logic [6:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [6:0]  redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        misalign_err;
    logic [15:0] fetch_cnt;

    logic [31:0] rom [0:31];
    int tests = 0;
    int failed = 0;

    // Reference model: abstract fetcher state (0=boot,1=run,2=halt)
    int m_state, m_pc, m_ipc, m_cnt;
    bit m_valid, m_mis;
    logic [31:0] m_inst;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[6:2]];

    instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_en(rom_en),
        .rom_data(rom_data), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .resume(resume), .halted(halted),
        .misalign_err(misalign_err), .fetch_cnt(fetch_cnt)
    );

    function automatic bit model_fetches();
        return (m_state == 1) && (!m_valid || inst_ready) && !redirect_valid;
    endfunction

    // Apply one clock of the fetch rules to the model
    task automatic model_edge();
        bit acc, fetch, redir, trap;
        int old_state;
        if (rst) begin
            m_state = 0; m_pc = 4; m_valid = 0; m_inst = 32'h0000_0013;
            m_ipc = 0; m_cnt = 0; m_mis = 0;
            return;
        end
        old_state = m_state;
        acc   = m_valid && inst_ready;
        fetch = model_fetches();
        redir = redirect_valid && (old_state != 0);
        trap  = 0;
`ifdef MISALIGN_TRAP_EN
        trap  = redir && ((int'(redirect_pc) % 4) != 0);
`endif
        m_mis = trap;
        if (acc) m_cnt = (m_cnt + 1) % 65536;
        if (redir) begin
            m_valid = 0;
            if (!trap) m_pc = (int'(redirect_pc) / 4) * 4;
        end else if (fetch) begin
            m_inst  = rom[m_pc / 4];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 4) % 128;
        end else if (acc) begin
            m_valid = 0;
        end
        if (old_state == 0) m_state = 1;
        else if (old_state == 1 && halt_req) m_state = 2;
        else if (old_state == 2 && resume && !halt_req) m_state = 1;
        if (trap) m_state = 2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 7'd0;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    // Reset, then step out of BOOT so the fetcher is running at pc 4
    task automatic start();
        idle_inputs();
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; tick(); rst = 1'b0; #1;
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        tests++; if (inst_out !== 32'h0000_0013) begin failed++; $display("FAIL reset_inst got %h want 00000013", inst_out); end
        tests++; if (inst_pc !== 7'd0) begin failed++; $display("FAIL reset_ipc got %0d want 0", inst_pc); end
        tests++; if (rom_addr !== 7'd4) begin failed++; $display("FAIL reset_pc got %0d want 4", rom_addr); end
        tests++; if (fetch_cnt !== 16'd0 || halted !== 1'b0 || misalign_err !== 1'b0) begin
            failed++; $display("FAIL reset_misc cnt %0d halted %0b mis %0b want 0 0 0", fetch_cnt, halted, misalign_err); end
        tests++; if (rom_en !== 1'b0) begin failed++; $display("FAIL boot_rom_en got %0b want 0", rom_en); end
    endtask

    task automatic test_sequential();
        start();
        tests++; if (inst_valid !== 1'b0) begin failed++; $display("FAIL seq_boot_valid got %0b want 0", inst_valid); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            tests++; if (inst_valid !== 1'b1 || inst_pc !== 7'(4*k) || inst_out !== rom[k]) begin
                failed++; $display("FAIL seq_fetch v %0b pc %0d inst %h want 1 %0d %h", inst_valid, inst_pc, inst_out, 4*k, rom[k]); end
            tests++; if (fetch_cnt !== 16'(k-1)) begin failed++; $display("FAIL seq_cnt got %0d want %0d", fetch_cnt, k-1); end
        end
        tick();
        tests++; if (fetch_cnt !== 16'd4) begin failed++; $display("FAIL seq_cnt4 got %0d want 4", fetch_cnt); end
    endtask

    task automatic test_backpressure();
        start(); tick(); tick();
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (rom_en !== 1'b0) begin failed++; $display("FAIL stall_rom_en got %0b want 0", rom_en); end
            tick();
            tests++; if (inst_valid !== 1'b1 || inst_pc !== 7'd8 || inst_out !== rom[2] || fetch_cnt !== 16'd1) begin
                failed++; $display("FAIL stall_hold v %0b pc %0d inst %h cnt %0d want 1 8 %h 1", inst_valid, inst_pc, inst_out, rom[2], fetch_cnt); end
        end
        inst_ready = 1'b1; tick();
        tests++; if (inst_pc !== 7'd12 || inst_valid !== 1'b1 || fetch_cnt !== 16'd2) begin
            failed++; $display("FAIL stall_resume pc %0d v %0b cnt %0d want 12 1 2", inst_pc, inst_valid, fetch_cnt); end
    endtask

    task automatic test_redirect();
        start(); tick(); tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 7'd8; #1;
        tests++; if (rom_en !== 1'b0) begin failed++; $display("FAIL redir_rom_en got %0b want 0", rom_en); end
        tick(); redirect_valid = 1'b0;
        tests++; if (inst_valid !== 1'b0 || rom_addr !== 7'd8 || fetch_cnt !== 16'd4) begin
            failed++; $display("FAIL redir_bubble v %0b pc %0d cnt %0d want 0 8 4", inst_valid, rom_addr, fetch_cnt); end
        tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 7'd8 || inst_out !== rom[2]) begin
            failed++; $display("FAIL redir_target v %0b pc %0d want 1 8", inst_valid, inst_pc); end
    endtask

    task automatic test_halt_redirect();
        start(); tick(); tick();
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 7'd12;
        tick(); halt_req = 1'b0; redirect_valid = 1'b0;
        tests++; if (halted !== 1'b1 || rom_addr !== 7'd12 || inst_valid !== 1'b0) begin
            failed++; $display("FAIL halt_redir halted %0b pc %0d v %0b want 1 12 0", halted, rom_addr, inst_valid); end
        tick(); #1;
        tests++; if (rom_en !== 1'b0 || rom_addr !== 7'd12) begin
            failed++; $display("FAIL halt_frozen en %0b pc %0d want 0 12", rom_en, rom_addr); end
        resume = 1'b1; halt_req = 1'b1; tick();
        tests++; if (halted !== 1'b1) begin failed++; $display("FAIL resume_vs_halt halted %0b want 1", halted); end
        halt_req = 1'b0; tick(); resume = 1'b0;
        tests++; if (halted !== 1'b0) begin failed++; $display("FAIL resume halted %0b want 0", halted); end
        tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 7'd12) begin
            failed++; $display("FAIL resume_fetch v %0b pc %0d want 1 12", inst_valid, inst_pc); end
    endtask

    task automatic test_wrap();
        start();
        redirect_valid = 1'b1; redirect_pc = 7'd124; tick(); redirect_valid = 1'b0;
        tick();
        tests++; if (inst_pc !== 7'd124 || inst_out !== rom[31]) begin failed++; $display("FAIL wrap_last pc %0d want 124", inst_pc); end
        tick();
        tests++; if (inst_pc !== 7'd0 || inst_valid !== 1'b1 || rom_addr !== 7'd4) begin
            failed++; $display("FAIL wrap_zero ipc %0d v %0b pc %0d want 0 1 4", inst_pc, inst_valid, rom_addr); end
    endtask

    task automatic test_reset_mid_stall();
        start(); tick(); inst_ready = 1'b0; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0; inst_ready = 1'b1;
        tests++; if (inst_valid !== 1'b0 || rom_addr !== 7'd4 || fetch_cnt !== 16'd0 || inst_pc !== 7'd0) begin
            failed++; $display("FAIL rst_stall v %0b pc %0d cnt %0d ipc %0d want 0 4 0 0", inst_valid, rom_addr, fetch_cnt, inst_pc); end
    endtask

    task automatic test_misalign();
        start(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 7'd10; tick(); redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        tests++; if (misalign_err !== 1'b1 || halted !== 1'b1 || rom_addr !== 7'd12) begin
            failed++; $display("FAIL misalign_trap mis %0b halted %0b pc %0d want 1 1 12", misalign_err, halted, rom_addr); end
        tick();
        tests++; if (misalign_err !== 1'b0) begin failed++; $display("FAIL misalign_pulse got %0b want 0", misalign_err); end
`else
        tests++; if (misalign_err !== 1'b0 || rom_addr !== 7'd8 || inst_valid !== 1'b0) begin
            failed++; $display("FAIL misalign_align mis %0b pc %0d v %0b want 0 8 0", misalign_err, rom_addr, inst_valid); end
        tick();
        tests++; if (inst_valid !== 1'b1 || inst_pc !== 7'd8) begin
            failed++; $display("FAIL misalign_fetch v %0b pc %0d want 1 8", inst_valid, inst_pc); end
`endif
    endtask

    task automatic test_random();
        start();
        for (int n = 0; n < 1500; n++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 7'($urandom_range(0, 127));
            halt_req       = ($urandom_range(0, 19) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            #1;
            tests++; if (rom_en !== model_fetches() || rom_addr !== 7'(m_pc)) begin
                failed++; $display("FAIL rnd_rom cyc %0d en %0b pc %0d want %0b %0d", n, rom_en, rom_addr, model_fetches(), m_pc); end
            tick();
            tests++; if (inst_valid !== m_valid || inst_pc !== 7'(m_ipc) || inst_out !== m_inst) begin
                failed++; $display("FAIL rnd_inst cyc %0d v %0b pc %0d inst %h want %0b %0d %h", n, inst_valid, inst_pc, inst_out, m_valid, m_ipc, m_inst); end
            tests++; if (fetch_cnt !== 16'(m_cnt) || halted !== (m_state == 2) || misalign_err !== m_mis) begin
                failed++; $display("FAIL rnd_ctl cyc %0d cnt %0d halted %0b mis %0b want %0d %0b %0b", n, fetch_cnt, halted, misalign_err, m_cnt, (m_state == 2), m_mis); end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        idle_inputs();
        rst = 1'b1;
        m_state = 0; m_pc = 4; m_valid = 0; m_inst = 32'h0000_0013; m_ipc = 0; m_cnt = 0; m_mis = 0;
        #1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_wrap();
        test_reset_mid_stall();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_instr_fetch_ctrl
